// File: rtl/bcd_quad_to_binary.sv
// Sequential reverse double-dabble: signed 4-digit BCD in, two's-complement DATA out.
// Optional BCD_BLANK_AS_ZERO_EN: blank code 4'b1011 converts as digit 0 instead of an error.
module bcd_quad_to_binary #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BCD_WIDTH  = 4,
    parameter int unsigned ITERATIONS = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  SIGNAL,
    input  logic [BCD_WIDTH-1:0]  BCD1,
    input  logic [BCD_WIDTH-1:0]  BCD2,
    input  logic [BCD_WIDTH-1:0]  BCD3,
    input  logic [BCD_WIDTH-1:0]  BCD4,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_BITS   = NUM_DIGITS * BCD_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(ITERATIONS + 1);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITERATIONS - 1);
    localparam logic [BCD_WIDTH-1:0] MAX_DIGIT = BCD_WIDTH'(9);
    localparam logic [BCD_WIDTH-1:0] CORR_MIN  = BCD_WIDTH'(8);
    localparam logic [BCD_WIDTH-1:0] CORR_SUB  = BCD_WIDTH'(3);
`ifdef BCD_BLANK_AS_ZERO_EN
    localparam logic [BCD_WIDTH-1:0] BLANK_CODE = BCD_WIDTH'(11);
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] SIGN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic [BCD_BITS-1:0]   bcd_q, bcd_d;
    logic [ITERATIONS-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                           invalid;
    logic [BCD_BITS-1:0]            clean_bcd;
    logic [BCD_WIDTH-1:0]           chk_digit;
    logic [BCD_BITS+ITERATIONS-1:0] shifted;
    logic [BCD_BITS-1:0]            shift_bcd;
    logic [ITERATIONS-1:0]          shift_bin;
    logic [BCD_WIDTH-1:0]           sft_digit;
    logic [DATA_WIDTH-1:0]          mag;

    // bcd_q holds the raw captured digits until CHECK replaces them with the cleaned copy.
    always_comb begin
        invalid   = 1'b0;
        clean_bcd = bcd_q;
        chk_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chk_digit = bcd_q[i*BCD_WIDTH +: BCD_WIDTH];
`ifdef BCD_BLANK_AS_ZERO_EN
            if (chk_digit == BLANK_CODE) begin
                clean_bcd[i*BCD_WIDTH +: BCD_WIDTH] = '0;
            end else if (chk_digit > MAX_DIGIT) begin
                invalid = 1'b1;
            end
`else
            if (chk_digit > MAX_DIGIT) begin
                invalid = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        shifted   = {bcd_q, bin_q} >> 1;
        shift_bcd = shifted[BCD_BITS+ITERATIONS-1 -: BCD_BITS];
        shift_bin = shifted[ITERATIONS-1:0];
        sft_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sft_digit = shift_bcd[i*BCD_WIDTH +: BCD_WIDTH];
            if (sft_digit >= CORR_MIN) begin
                shift_bcd[i*BCD_WIDTH +: BCD_WIDTH] = sft_digit - CORR_SUB;
            end
        end
    end

    assign mag = DATA_WIDTH'(bin_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = SIGNAL;
                    bcd_d   = {BCD1, BCD2, BCD3, BCD4};
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (invalid) begin
                    error_d = 1'b1;
                    data_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    bcd_d   = clean_bcd;
                    bin_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shift_bcd;
                bin_d = shift_bin;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // Negating zero yields zero, so no negative-zero special case is needed.
                data_d  = sign_q ? -mag : mag;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign DATA  = data_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule
